// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter sequencer: command opcodes and FSM states.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'b00,
    OP_STOP  = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHold = 2'b10,
    StDone = 2'b11
  } state_e;

endpackage

// File: rtl/counter_ctrl_if.sv
// Command port of the counter sequencer: valid/ready handshake with opcode and load data.
interface counter_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();
  import counter_ctrl_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/counter_presc.sv
// Prescaler: raises step once every max(period,1) cycles while run is high.
module counter_presc #(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run,
  input  logic               i_restart,
  input  logic [PRESC_W-1:0] i_period,
  output logic               o_step
);

  logic [PRESC_W-1:0] r_psc;
  logic [PRESC_W-1:0] w_psc_d;
  logic [PRESC_W-1:0] w_last;

  // A period of 0 behaves like 1, i.e. a step every cycle.
  assign w_last = (i_period == '0) ? '0 : i_period - PRESC_W'(1);

  // >= rather than == so a period shrunk mid-run cannot strand psc above the terminal value.
  assign o_step = i_run && (r_psc >= w_last);

  // Next prescaler value: restart wins, counts only while running, holds otherwise.
  always_comb begin
    w_psc_d = r_psc;
    if (i_restart) begin
      w_psc_d = '0;
    end else if (i_run) begin
      w_psc_d = o_step ? '0 : r_psc + PRESC_W'(1);
    end
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_psc <= '0;
    end else begin
      r_psc <= w_psc_d;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Counter sequencer: takes START/STOP/LOAD/CLEAR commands and drives the counter's
// clear/load/increment pins, pacing increments and stopping or wrapping at a limit.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 16,
  parameter bit          WRAP    = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  counter_ctrl_if.slave      io_cmd,
  input  logic [PRESC_W-1:0] i_period,
  input  logic [WIDTH-1:0]   i_limit,
  input  logic [WIDTH-1:0]   i_count,
  output logic               o_cnt_rst,
  output logic               o_cnt_en,
  output logic               o_cnt_ld,
  output logic [WIDTH-1:0]   o_cnt_v,
  output logic               o_busy,
  output logic               o_done
);

  state_e           r_state, w_state_d;
  logic             r_cmd_ready, w_cmd_ready_d;
  logic             r_cnt_rst, w_cnt_rst_d;
  logic             r_cnt_en, w_cnt_en_d;
  logic             r_cnt_ld, w_cnt_ld_d;
  logic [WIDTH-1:0] r_cnt_v, w_cnt_v_d;
  logic             r_busy;
  logic             r_done, w_done_d;

  logic             w_accept;
  logic             w_restart;
  logic             w_step;
  logic [WIDTH-1:0] w_pc;

  assign w_accept = io_cmd.cmd_valid && r_cmd_ready;

  // START, CLEAR and a LOAD issued while running all realign the increment cadence.
  assign w_restart = w_accept &&
                     ((io_cmd.cmd_op == OP_START) || (io_cmd.cmd_op == OP_CLEAR) ||
                      ((io_cmd.cmd_op == OP_LOAD) && (r_state == StRun)));

  // Value the counter will hold once the strobe currently on its pins lands.
  assign w_pc = r_cnt_rst ? '0 :
                r_cnt_ld  ? r_cnt_v :
                            i_count + WIDTH'(r_cnt_en);

  counter_presc #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_run     (r_state == StRun),
    .i_restart (w_restart),
    .i_period  (i_period),
    .o_step    (w_step)
  );

  // Next state and next registered outputs; an accepted command pre-empts a step.
  always_comb begin
    w_state_d     = r_state;
    w_cmd_ready_d = ~w_accept;
    w_cnt_rst_d   = 1'b0;
    w_cnt_en_d    = 1'b0;
    w_cnt_ld_d    = 1'b0;
    w_cnt_v_d     = '0;
    w_done_d      = 1'b0;
    if (w_accept) begin
      unique case (io_cmd.cmd_op)
        OP_START: w_state_d = StRun;
        OP_STOP: begin
          if (r_state == StRun) begin
            w_state_d = StHold;
          end
        end
        OP_LOAD: begin
          w_cnt_ld_d = 1'b1;
          w_cnt_v_d  = io_cmd.cmd_data;
        end
        OP_CLEAR: begin
          w_cnt_rst_d = 1'b1;
          w_state_d   = StIdle;
        end
        default: ;
      endcase
    end else if (w_step) begin
      if (w_pc != i_limit) begin
        w_cnt_en_d = 1'b1;
      end else if (WRAP) begin
        w_cnt_ld_d = 1'b1;
        w_cnt_v_d  = '0;
        w_done_d   = 1'b1;
      end else begin
        w_done_d  = 1'b1;
        w_state_d = StDone;
      end
    end
  end

  // State and output registers; reset leaves a single counter-clear pulse behind.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cmd_ready <= 1'b0;
      r_cnt_rst   <= 1'b1;
      r_cnt_en    <= 1'b0;
      r_cnt_ld    <= 1'b0;
      r_cnt_v     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cmd_ready <= w_cmd_ready_d;
      r_cnt_rst   <= w_cnt_rst_d;
      r_cnt_en    <= w_cnt_en_d;
      r_cnt_ld    <= w_cnt_ld_d;
      r_cnt_v     <= w_cnt_v_d;
      r_busy      <= (w_state_d == StRun);
      r_done      <= w_done_d;
    end
  end

  assign io_cmd.cmd_ready = r_cmd_ready;
  assign o_cnt_rst        = r_cnt_rst;
  assign o_cnt_en         = r_cnt_en;
  assign o_cnt_ld         = r_cnt_ld;
  assign o_cnt_v          = r_cnt_v;
  assign o_busy           = r_busy;
  assign o_done           = r_done;

endmodule
